data_bus_arbiter: RTL and testbench

//  Responder side of the data-memory bus handshake: masters raise req and wait for grant.

---
 rtl/data_bus_arbiter_pkg.sv | 22 ++
 rtl/data_bus_arbiter_rr_priority_pick.sv | 30 +++
 rtl/data_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_data_bus_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared constants and index helpers for the data-bus arbiter.
// Pure definitions: no state, no latency, no flow control.
package data_bus_arbiter_pkg;
    localparam int MST_CPU = 0;
    localparam int MST_DMA = 1;
    localparam int DBUS_AW = 8;
    localparam int DBUS_DW = 8;
    localparam int OWNER_W = 3;

    typedef logic [OWNER_W-1:0] owner_t;

    function automatic logic [7:0] idx_onehot(input owner_t idx);
        return 8'b1 << idx;
    endfunction

    function automatic owner_t wrap_inc(input owner_t idx, input int n);
        logic [OWNER_W:0] nx;
        nx = {1'b0, idx} + 1'b1;
        if (int'(nx) >= n) return '0;
        return nx[OWNER_W-1:0];
    endfunction
endpackage

// File: rtl/data_bus_arbiter_rr_priority_pick.sv
// Circular first-one finder: first set, non-excluded request scanning from i_start.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever an eligible request exists.
import data_bus_arbiter_pkg::*;

module rr_priority_pick #(
    parameter int N = 2
) (
    input  logic [7:0]         i_req,
    input  logic [7:0]         i_excl,
    input  logic [OWNER_W-1:0] i_start,
    output logic               o_vld,
    output logic [OWNER_W-1:0] o_idx
);
    always_comb begin
        int w_pos;
        o_vld = 1'b0;
        o_idx = '0;
        w_pos = 0;
        for (int k = 0; k < N; k++) begin
            // i_start < N and k < N, so one wrap subtraction is enough
            w_pos = int'(i_start) + k;
            if (w_pos >= N) w_pos = w_pos - N;
            if (!o_vld && i_req[3'(w_pos)] && !i_excl[3'(w_pos)]) begin
                o_vld = 1'b1;
                o_idx = 3'(w_pos);
            end
        end
    end
endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin owner arbiter for the 8-bit data bus; muxes the owner's strobes/addr/wdata.
// Latency: grant and bus outputs combinational (zero-cycle); ownership registered.
// Backpressure: masters hold req until granted; DBUS_ARB_TIMEOUT_EN enables owner preemption.
import data_bus_arbiter_pkg::*;

module data_bus_arbiter #(
    parameter int N_MST          = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_MST-1:0]       mst_req,
    input  logic [N_MST-1:0]       mst_wr,
    input  logic [N_MST-1:0]       mst_rd,
    input  logic [8*N_MST-1:0]     mst_addr,
    input  logic [8*N_MST-1:0]     mst_wdata,
    output logic [N_MST-1:0]       mst_grant,
    output logic                   bus_wr,
    output logic                   bus_rd,
    output logic [DBUS_AW-1:0]     bus_addr,
    output logic [DBUS_DW-1:0]     bus_wdata,
    output logic                   bus_busy,
    output logic [OWNER_W-1:0]     bus_owner,
    output logic                   timeout_evt
);
    if (N_MST < 2 || N_MST > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32) begin : g_bad_cfg
        $error("data_bus_arbiter: unsupported N_MST/TIMEOUT_CYCLES");
    end

    logic               r_locked;
    owner_t             r_owner;
    owner_t             r_rr_ptr;

    logic [7:0]         w_req_x;
    logic [7:0]         w_wr_x;
    logic [7:0]         w_rd_x;
    logic [7:0]         w_excl;
    logic               w_owned;
    logic               w_pick_vld;
    owner_t             w_pick_idx;
    logic               w_gnt_vld;
    owner_t             w_gnt_idx;

    always_comb begin
        w_req_x = '0;
        w_wr_x  = '0;
        w_rd_x  = '0;
        w_req_x[N_MST-1:0] = mst_req;
        w_wr_x[N_MST-1:0]  = mst_wr;
        w_rd_x[N_MST-1:0]  = mst_rd;
    end

    assign w_owned = r_locked & w_req_x[r_owner];

    rr_priority_pick #(.N(N_MST)) u_pick (
        .i_req   (w_req_x),
        .i_excl  (w_excl),
        .i_start (r_rr_ptr),
        .o_vld   (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    // Grants are gated by rst_n so nothing reaches the bus while reset is asserted
    assign w_gnt_vld = rst_n & (w_owned | w_pick_vld);
    assign w_gnt_idx = w_owned ? r_owner : w_pick_idx;
    assign bus_busy  = w_gnt_vld;

`ifdef DBUS_ARB_TIMEOUT_EN
    localparam logic [4:0] HOLD_LAST = 5'(TIMEOUT_CYCLES - 1);

    logic [4:0] r_hold_cnt;
    logic       r_tmo;
    logic       w_preempt;

    assign w_preempt   = w_owned & (r_hold_cnt == HOLD_LAST)
                       & (|(w_req_x & ~idx_onehot(r_owner)));
    assign w_excl      = r_tmo ? idx_onehot(r_owner) : '0;
    assign timeout_evt = rst_n & r_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_tmo      <= 1'b0;
        end else begin
            r_tmo      <= w_preempt;
            r_hold_cnt <= (w_owned && !w_preempt) ? r_hold_cnt + 5'd1 : 5'd0;
        end
    end
`else
    assign w_excl      = '0;
    assign timeout_evt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= 1'b0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else if (w_owned) begin
`ifdef DBUS_ARB_TIMEOUT_EN
            // Owner index is kept so the next cycle can exclude it from arbitration
            if (w_preempt) begin
                r_locked <= 1'b0;
                r_rr_ptr <= wrap_inc(r_owner, N_MST);
            end
`endif
        end else if (w_pick_vld) begin
            r_locked <= 1'b1;
            r_owner  <= w_pick_idx;
            r_rr_ptr <= wrap_inc(w_pick_idx, N_MST);
        end else begin
            r_locked <= 1'b0;
        end
    end

    always_comb begin
        mst_grant = '0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_owner = '0;
        if (w_gnt_vld) begin
            bus_owner = w_gnt_idx;
            bus_wr    = w_wr_x[w_gnt_idx];
            bus_rd    = w_rd_x[w_gnt_idx] & ~w_wr_x[w_gnt_idx];
            for (int i = 0; i < N_MST; i++) begin
                if (w_gnt_idx == 3'(i)) begin
                    mst_grant[i] = 1'b1;
                    bus_addr     = mst_addr[i*8 +: 8];
                    bus_wdata    = mst_wdata[i*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench: a behavioural ownership model predicts each cycle's bus outputs,
// a monitor compares them against the DUT one cycle at a time.
import data_bus_arbiter_pkg::*;

module tb_data_bus_arbiter;
    localparam int N   = 3;
    localparam int TMO = 16;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     mst_req, mst_wr, mst_rd;
    logic [8*N-1:0]   mst_addr, mst_wdata;
    logic [N-1:0]     mst_grant;
    logic             bus_wr, bus_rd, bus_busy, timeout_evt;
    logic [7:0]       bus_addr, bus_wdata;
    logic [2:0]       bus_owner;

    data_bus_arbiter #(.N_MST(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mst_req(mst_req), .mst_wr(mst_wr), .mst_rd(mst_rd),
        .mst_addr(mst_addr), .mst_wdata(mst_wdata),
        .mst_grant(mst_grant), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_busy(bus_busy),
        .bus_owner(bus_owner), .timeout_evt(timeout_evt)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         wr;
        logic         rd;
        logic [7:0]   addr;
        logic [7:0]   wdata;
        logic         busy;
        logic [2:0]   owner;
        logic         evt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Model state: who holds the bus (-1 = nobody), where the search starts,
    // how many cycles the holder has kept it, and any master barred for one cycle
    int m_holder = -1;
    int m_ptr    = 0;
    int m_cnt    = 0;
    int m_excl   = -1;
    bit m_evt    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic rstv, input logic [N-1:0] req, input logic [N-1:0] wr,
                         input logic [N-1:0] rd, input logic [8*N-1:0] addr,
                         input logic [8*N-1:0] wdata);
        exp_t e;
        int   g;
        bit   kept;
        @(negedge clk);
        rst_n = rstv; mst_req = req; mst_wr = wr; mst_rd = rd;
        mst_addr = addr; mst_wdata = wdata;
        e = '0;
        if (!rstv) begin
            m_holder = -1; m_ptr = 0; m_cnt = 0; m_excl = -1; m_evt = 0;
        end else begin
            g    = -1;
            kept = (m_holder >= 0) && req[m_holder];
            if (kept) g = m_holder;
            else begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (g < 0 && req[idx] && idx != m_excl) g = idx;
                end
            end
            e.evt  = m_evt;
            m_evt  = 0;
            m_excl = -1;
            if (kept) begin
                m_cnt++;
`ifdef DBUS_ARB_TIMEOUT_EN
                if (m_cnt == TMO && (req & ~(N'(1) << g)) != 0) begin
                    m_holder = -1; m_ptr = (g + 1) % N; m_excl = g; m_evt = 1; m_cnt = 0;
                end
`endif
            end else if (g >= 0) begin
                m_holder = g; m_ptr = (g + 1) % N; m_cnt = 0;
            end else begin
                m_holder = -1;
            end
            if (g >= 0) begin
                e.gnt[g] = 1'b1;
                e.wr     = wr[g];
                e.rd     = rd[g] & ~wr[g];
                e.addr   = addr[g*8 +: 8];
                e.wdata  = wdata[g*8 +: 8];
                e.busy   = 1'b1;
                e.owner  = 3'(g);
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, '0, '0, '0, '0, '0);
    endtask

    initial begin : monitor
        exp_t e, got;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {mst_grant, bus_wr, bus_rd, bus_addr, bus_wdata, bus_busy, bus_owner, timeout_evt};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL bus_cycle%0d got gnt=%b wr=%b rd=%b addr=%h wd=%h busy=%b own=%0d evt=%b exp gnt=%b wr=%b rd=%b addr=%h wd=%h busy=%b own=%0d evt=%b",
                             cyc, got.gnt, got.wr, got.rd, got.addr, got.wdata, got.busy, got.owner, got.evt,
                             e.gnt, e.wr, e.rd, e.addr, e.wdata, e.busy, e.owner, e.evt);
                end
                cyc++;
            end
        end
    end

    initial begin : stim
        logic [N-1:0]   req;
        logic [8*N-1:0] a, d;
        int             waited;
        rst_n = 1'b0; mst_req = '0; mst_wr = '0; mst_rd = '0; mst_addr = '0; mst_wdata = '0;

        // Reset with both masters requesting, then release: master 0 wins at once
        drive(1'b0, 3'b011, 3'b011, '0, 24'h00_2211, 24'h00_6655);
        drive(1'b0, 3'b011, 3'b011, '0, 24'h00_2211, 24'h00_6655);
        drive(1'b1, 3'b011, 3'b001, '0, 24'h00_2211, 24'h00_6655);
        idle(2);

        // Single-cycle CPU read, then a back-to-back CPU access
        drive(1'b1, 3'(1 << MST_CPU), '0, 3'b001, 24'h00_0040, '0);
        drive(1'b1, 3'(1 << MST_CPU), 3'b001, '0, 24'h00_0041, 24'h00_0033);
        idle(1);

        // Round-robin handoff without bubbles
        drive(1'b1, 3'b011, 3'b011, 3'b000, 24'h00_B0A0, 24'h00_D0C0);
        drive(1'b1, 3'b010, 3'b010, 3'b000, 24'h00_B0A0, 24'h00_D0C0);
        drive(1'b1, 3'b001, 3'b000, 3'b001, 24'h00_B0A0, 24'h00_D0C0);
        drive(1'b1, 3'b010, 3'b000, 3'b010, 24'h00_B0A0, 24'h00_D0C0);
        idle(1);

        // DMA burst of 10 cycles; CPU waits from cycle 2 onward
        for (int c = 0; c < 10; c++)
            drive(1'b1, (c >= 2) ? 3'b011 : 3'(1 << MST_DMA), 3'b010, 3'b001, 24'h00_7788, 24'h00_99AA);
        drive(1'b1, 3'b001, 3'b000, 3'b001, 24'h00_7788, 24'h00_99AA);
        idle(1);

        // Both strobes set: write wins
        drive(1'b1, 3'b001, 3'b001, 3'b001, 24'h00_0012, 24'h00_00A5);
        idle(1);

        // Long DMA ownership with CPU contending
        drive(1'b1, 3'b010, '0, 3'b010, 24'h00_5500, '0);
        for (int c = 0; c < 2 * TMO + 4; c++)
            drive(1'b1, 3'b011, '0, 3'b011, 24'h00_5544, '0);
        idle(2);

        // Randomized traffic with burst-like request persistence and rare resets
        req = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 2) == 0) req[b] = ~req[b];
            a = {$urandom, $urandom};
            d = {$urandom, $urandom};
            drive(($urandom_range(0, 199) != 0), req, 3'($urandom), 3'($urandom), a, d);
        end
        idle(2);

        waited = 0;
        while (sb_q.size() != 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #4;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
